// File: rtl/mem_responder.sv
// Memory-side responder for the eLC-3 MIO_EN/R_W request interface.
// Runs multi-cycle accesses to an external async SRAM or to the keyboard/display
// registers in the MMIO page, then raises R until the control FSM drops MIO_EN.
module mem_responder #(
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [15:0] MMIO_BASE   = 16'hFE00
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    output logic [15:0] Mem_Data,
    output logic        R,
    output logic [15:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_Out,
    input  logic [15:0] SRAM_DQ_In,
    output logic        SRAM_DQ_OE,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    input  logic        KB_Valid,
    input  logic [7:0]  KB_Data,
    input  logic        Disp_Ready,
    output logic        DDR_Valid,
    output logic [7:0]  DDR_Data
);

    localparam logic [3:0] WaitCnt = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    state_e      state_q;
    logic [3:0]  count_q;
    logic        rw_q;
    logic        is_mmio_q;
    logic [7:0]  mmio_off_q;
    logic [7:0]  wbyte_q;

    logic [15:0] mem_data_q;
    logic        r_q;
    logic [15:0] sram_addr_q;
    logic [15:0] sram_dq_out_q;
    logic        sram_dq_oe_q;
    logic        sram_ce_n_q;
    logic        sram_oe_n_q;
    logic        sram_we_n_q;

    logic        kbsr_rdy_q;
    logic [7:0]  kbdr_q;
    logic        dsr_rdy_q;
    logic        ddr_valid_q;
    logic [7:0]  ddr_data_q;

    logic        req_is_mmio;
    logic        mmio_exit;
    logic        kbdr_rd;
    logic        ddr_wr;
    logic [15:0] mmio_rdata;

    // Request decode and MMIO side effects, all taken at the ACCESS exit edge
    always_comb begin
        req_is_mmio = (MAR[15:8] == MMIO_BASE[15:8]);
        mmio_exit   = (state_q == StAccess) && is_mmio_q && (count_q == 4'd0);
        kbdr_rd     = mmio_exit && !rw_q && (mmio_off_q == 8'h02);
        ddr_wr      = mmio_exit && rw_q && (mmio_off_q == 8'h06);
        case (mmio_off_q)
            8'h00:   mmio_rdata = {kbsr_rdy_q, 15'b0};
            8'h02:   mmio_rdata = {8'b0, kbdr_q};
            8'h04:   mmio_rdata = {dsr_rdy_q, 15'b0};
            default: mmio_rdata = 16'h0000;
        endcase
    end

    // Access FSM with registered SRAM strobes, read data and ready
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= StIdle;
            count_q       <= 4'd0;
            rw_q          <= 1'b0;
            is_mmio_q     <= 1'b0;
            mmio_off_q    <= 8'h00;
            wbyte_q       <= 8'h00;
            mem_data_q    <= 16'h0000;
            r_q           <= 1'b0;
            sram_addr_q   <= 16'h0000;
            sram_dq_out_q <= 16'h0000;
            sram_dq_oe_q  <= 1'b0;
            sram_ce_n_q   <= 1'b1;
            sram_oe_n_q   <= 1'b1;
            sram_we_n_q   <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    r_q <= 1'b0;
                    if (MIO_EN) begin
                        state_q    <= StAccess;
                        rw_q       <= R_W;
                        is_mmio_q  <= req_is_mmio;
                        mmio_off_q <= MAR[7:0];
                        wbyte_q    <= MDR[7:0];
                        if (req_is_mmio) begin
                            count_q <= 4'd0;
                        end else begin
                            count_q     <= WaitCnt;
                            sram_ce_n_q <= 1'b0;
                            sram_addr_q <= MAR;
                            if (R_W) begin
                                sram_dq_out_q <= MDR;
                                sram_dq_oe_q  <= 1'b1;
                                // WE_N stays high on the final ACCESS cycle
                                sram_we_n_q   <= (WaitCnt == 4'd0);
                            end else begin
                                sram_oe_n_q <= 1'b0;
                            end
                        end
                    end
                end
                StAccess: begin
                    if (count_q != 4'd0) begin
                        count_q <= count_q - 4'd1;
                        if (rw_q && !is_mmio_q) begin
                            sram_we_n_q <= (count_q == 4'd1);
                        end
                    end else begin
                        sram_ce_n_q  <= 1'b1;
                        sram_oe_n_q  <= 1'b1;
                        sram_we_n_q  <= 1'b1;
                        sram_dq_oe_q <= 1'b0;
                        if (!rw_q) begin
                            mem_data_q <= is_mmio_q ? mmio_rdata : SRAM_DQ_In;
                        end
                        // A requester that gave up mid-access never sees R
                        state_q <= MIO_EN ? StDone : StIdle;
                    end
                end
                StDone: begin
                    if (MIO_EN) begin
                        r_q <= 1'b1;
                    end else begin
                        r_q     <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    r_q     <= 1'b0;
                end
            endcase
        end
    end

    // Keyboard status/data: a new key wins over a same-cycle KBDR read clear
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            kbsr_rdy_q <= 1'b0;
            kbdr_q     <= 8'h00;
        end else if (KB_Valid) begin
            kbsr_rdy_q <= 1'b1;
            kbdr_q     <= KB_Data;
        end else if (kbdr_rd) begin
            kbsr_rdy_q <= 1'b0;
        end
    end

    // Display status and data: DDR write pulses the display and clears ready
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            dsr_rdy_q   <= 1'b1;
            ddr_valid_q <= 1'b0;
            ddr_data_q  <= 8'h00;
        end else begin
            ddr_valid_q <= ddr_wr;
            if (ddr_wr) begin
                ddr_data_q <= wbyte_q;
                dsr_rdy_q  <= 1'b0;
            end else if (Disp_Ready) begin
                dsr_rdy_q <= 1'b1;
            end
        end
    end

    assign Mem_Data    = mem_data_q;
    assign R           = r_q;
    assign SRAM_ADDR   = sram_addr_q;
    assign SRAM_DQ_Out = sram_dq_out_q;
    assign SRAM_DQ_OE  = sram_dq_oe_q;
    assign SRAM_CE_N   = sram_ce_n_q;
    assign SRAM_OE_N   = sram_oe_n_q;
    assign SRAM_WE_N   = sram_we_n_q;
    assign DDR_Valid   = ddr_valid_q;
    assign DDR_Data    = ddr_data_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with an SRAM model, strobe monitors and a
// read-data scoreboard.
module tb_mem_responder;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        MIO_EN = 1'b0;
    logic        R_W = 1'b0;
    logic [15:0] MAR = 16'h0000;
    logic [15:0] MDR = 16'h0000;
    logic [15:0] Mem_Data;
    logic        R;
    logic [15:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_Out;
    logic [15:0] SRAM_DQ_In;
    logic        SRAM_DQ_OE;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic        KB_Valid = 1'b0;
    logic [7:0]  KB_Data = 8'h00;
    logic        Disp_Ready = 1'b0;
    logic        DDR_Valid;
    logic [7:0]  DDR_Data;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb[$];
    logic [15:0] sram [0:65535];

    int oe_cnt = 0, we_cnt = 0, dqoe_cnt = 0, ce_cnt = 0, ddr_cnt = 0;
    logic ce_prev = 1'b1;
    logic [7:0] ddr_last = 8'h00;

    mem_responder #(
        .WAIT_STATES(2),
        .MMIO_BASE  (16'hFE00)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .MIO_EN     (MIO_EN),
        .R_W        (R_W),
        .MAR        (MAR),
        .MDR        (MDR),
        .Mem_Data   (Mem_Data),
        .R          (R),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_DQ_Out(SRAM_DQ_Out),
        .SRAM_DQ_In (SRAM_DQ_In),
        .SRAM_DQ_OE (SRAM_DQ_OE),
        .SRAM_CE_N  (SRAM_CE_N),
        .SRAM_OE_N  (SRAM_OE_N),
        .SRAM_WE_N  (SRAM_WE_N),
        .KB_Valid   (KB_Valid),
        .KB_Data    (KB_Data),
        .Disp_Ready (Disp_Ready),
        .DDR_Valid  (DDR_Valid),
        .DDR_Data   (DDR_Data)
    );

    always #5 Clk = ~Clk;

    // Async SRAM: combinational read, write while CE/WE low and bus driven
    assign SRAM_DQ_In = (!SRAM_CE_N && !SRAM_OE_N) ? sram[SRAM_ADDR] : 16'h0000;

    always @(posedge Clk) begin
        if (!Reset) sram[16'h3000] <= 16'h1234;
        else if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_OE) sram[SRAM_ADDR] <= SRAM_DQ_Out;
    end

    // Strobe and display monitors, sampled mid-cycle
    always @(negedge Clk) begin
        if (!SRAM_OE_N) oe_cnt++;
        if (!SRAM_WE_N) we_cnt++;
        if (SRAM_DQ_OE) dqoe_cnt++;
        if (!SRAM_CE_N && ce_prev) ce_cnt++;
        ce_prev = SRAM_CE_N;
        if (DDR_Valid) begin
            ddr_cnt++;
            ddr_last = DDR_Data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full request/ready handshake; hold = extra cycles MIO_EN stays high with R up
    task automatic do_access(input string tag, input logic rw, input logic [15:0] addr,
                             input logic [15:0] wdata, input int exp_lat, input int hold,
                             input logic [15:0] exp_rd);
        int lat;
        logic [15:0] e;
        if (!rw) sb.push_back(exp_rd);
        @(negedge Clk);
        MIO_EN = 1'b1;
        R_W    = rw;
        MAR    = addr;
        MDR    = wdata;
        lat    = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge Clk);
            #1;
            if (R === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, lat, exp_lat);
        if (!rw) begin
            e = sb.pop_front();
            check({tag, " rdata"}, {16'h0, Mem_Data}, {16'h0, e});
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge Clk);
            #1;
            check({tag, " R held"}, {31'h0, R}, 32'd1);
        end
        @(negedge Clk);
        MIO_EN = 1'b0;
        @(posedge Clk);
        #1;
        check({tag, " R drop"}, {31'h0, R}, 32'd0);
    endtask

    int oe0, we0, dq0, ce0, dd0;

    initial begin
        // Reset values
        repeat (2) @(posedge Clk);
        #1;
        check("rst R", {31'h0, R}, 32'd0);
        check("rst Mem_Data", {16'h0, Mem_Data}, 32'h0);
        check("rst strobes", {28'h0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE}, 32'hE);
        check("rst SRAM_ADDR", {16'h0, SRAM_ADDR}, 32'h0);
        check("rst SRAM_DQ_Out", {16'h0, SRAM_DQ_Out}, 32'h0);
        check("rst DDR", {23'h0, DDR_Valid, DDR_Data}, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;

        // 1: SRAM read with two wait states
        oe0 = oe_cnt; we0 = we_cnt;
        do_access("t1 read", 1'b0, 16'h3000, 16'h0000, 4, 0, 16'h1234);
        check("t1 OE_N low cycles", oe_cnt - oe0, 3);
        check("t1 WE_N low cycles", we_cnt - we0, 0);

        // 2: SRAM write then read-back
        we0 = we_cnt; dq0 = dqoe_cnt; oe0 = oe_cnt;
        do_access("t2 write", 1'b1, 16'h4000, 16'hBEEF, 4, 0, 16'h0000);
        check("t2 WE_N low cycles", we_cnt - we0, 2);
        check("t2 DQ_OE cycles", dqoe_cnt - dq0, 3);
        check("t2 OE_N low cycles", oe_cnt - oe0, 0);
        do_access("t2 readback", 1'b0, 16'h4000, 16'h0000, 4, 0, 16'hBEEF);

        // 3: keyboard registers
        ce0 = ce_cnt;
        @(negedge Clk);
        KB_Valid = 1'b1;
        KB_Data  = 8'h41;
        @(negedge Clk);
        KB_Valid = 1'b0;
        KB_Data  = 8'h00;
        do_access("t3 KBSR set", 1'b0, 16'hFE00, 16'h0000, 2, 0, 16'h8000);
        do_access("t3 KBDR", 1'b0, 16'hFE02, 16'h0000, 2, 0, 16'h0041);
        do_access("t3 KBSR clr", 1'b0, 16'hFE00, 16'h0000, 2, 0, 16'h0000);
        do_access("t3 unmapped", 1'b0, 16'hFE10, 16'h0000, 2, 0, 16'h0000);
        check("t3 no SRAM CE", ce_cnt - ce0, 0);

        // 4: display registers
        do_access("t4 DSR rst", 1'b0, 16'hFE04, 16'h0000, 2, 0, 16'h8000);
        dd0 = ddr_cnt;
        do_access("t4 DDR write", 1'b1, 16'hFE06, 16'h0048, 2, 0, 16'h0000);
        check("t4 DDR_Valid pulses", ddr_cnt - dd0, 1);
        check("t4 DDR_Data", {24'h0, ddr_last}, 32'h48);
        do_access("t4 DSR busy", 1'b0, 16'hFE04, 16'h0000, 2, 0, 16'h0000);
        @(negedge Clk);
        Disp_Ready = 1'b1;
        @(negedge Clk);
        Disp_Ready = 1'b0;
        do_access("t4 DSR ready", 1'b0, 16'hFE04, 16'h0000, 2, 0, 16'h8000);

        // 5: MIO_EN held in DONE
        ce0 = ce_cnt;
        do_access("t5 hold", 1'b0, 16'h3000, 16'h0000, 4, 5, 16'h1234);
        check("t5 single access", ce_cnt - ce0, 1);

        // 6: reset during write ACCESS
        @(negedge Clk);
        MIO_EN = 1'b1;
        R_W    = 1'b1;
        MAR    = 16'h5000;
        MDR    = 16'h1111;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        check("t6 mid-write CE_N", {31'h0, SRAM_CE_N}, 32'd0);
        Reset  = 1'b0;
        MIO_EN = 1'b0;
        #1;
        check("t6 abort strobes", {28'h0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE}, 32'hE);
        check("t6 abort R", {31'h0, R}, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("t6 idle after reset", {30'h0, SRAM_CE_N, R}, 32'h2);
        do_access("t6 post-reset read", 1'b0, 16'h3000, 16'h0000, 4, 0, 16'h1234);

        check("scoreboard empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
